serial_to_parallel_rx: RTL and testbench
========================================

Name: serial_to_parallel_rx

Overview:
- Receive-side counterpart of the lane serializer. Consumes one serial lane, one bit per clk, MSB first.
- Hunts for byte alignment on the COM character and declares lock after LOCK_COUNT consecutive aligned COMs.
- When locked, emits each deserialized non-COM byte with a one-cycle valid pulse. One instance per lane; output feeds the receive FIFO.

Parameters:
- DATA_SIZE, 8, width of deserialized word in bits.
- COM_CHAR, 8'hBC, alignment/idle character.
- LOCK_COUNT, 4, consecutive aligned COMs needed to enter LOCKED (range 1..15).
- LOSS_BYTES, 16, consecutive non-COM words that drop lock (used only with LOCK_LOSS_EN).

Ports:
- clk  input  1  bit clock; one serial bit per rising edge.
- reset  input  1  asynchronous, active-high reset.
- in  input  1  serial data, MSB of each word first.
- out  output  DATA_SIZE  last delivered data word.
- valid_out  output  1  one-cycle pulse; out holds a new word.
- active  output  1  high while in LOCKED.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, port reset.
- Reset (async assert, any state):
  - state=SEARCH; shift reg=0; bit_cnt=0; com_cnt=0.
  - out=0; valid_out=0; active=0.
- Window:
  - next_sr = {sr[DATA_SIZE-2:0], in}, combinational.
  - All decisions on an edge use next_sr, the word that includes the bit sampled on that edge.
  - sr <= next_sr every cycle in every state.
- SEARCH:
  - Checked every cycle.
  - If next_sr==COM_CHAR: bit_cnt<=0, com_cnt<=1. Go to LOCKED if LOCK_COUNT==1, else ALIGN.
  - Otherwise stay in SEARCH.
- ALIGN:
  - bit_cnt increments mod DATA_SIZE. A word boundary is the edge where bit_cnt==DATA_SIZE-1.
  - At a boundary, if next_sr==COM_CHAR: com_cnt+1. If that reaches LOCK_COUNT, go to LOCKED and set active<=1 on the same edge.
  - At a boundary, if next_sr!=COM_CHAR: com_cnt<=0, go to SEARCH. A COM in that same window is not re-detected on that edge.
  - No valid_out pulses in ALIGN.
- LOCKED:
  - bit_cnt keeps counting. At each boundary:
    - If next_sr!=COM_CHAR: out<=next_sr, valid_out<=1 for that cycle only. Zero extra latency: out changes on the edge that samples the word's last bit.
    - If next_sr==COM_CHAR (idle): out holds, valid_out=0.
  - valid_out is 0 on all non-boundary cycles.
  - active=1 throughout.
- Spacing: consecutive valid_out pulses are at least DATA_SIZE cycles apart.
- No back-pressure: the downstream stage must accept every pulse.

Optional Feature:
- Macro: LOCK_LOSS_EN.
- With the macro:
  - LOCKED keeps a counter of consecutive non-COM words, cleared on each COM.
  - When the LOSS_BYTES-th consecutive non-COM word is reached, that word is still delivered (valid_out=1).
  - On the same edge: state goes to SEARCH, active<=0, com_cnt<=0.
- Without the macro: LOCKED is left only by reset; the counter is not built.

Test Plan:
- Reset: assert reset mid-cycle with no clock edge → out=0, valid_out=0, active=0 immediately. Release, feed all-zero bits for 40 cycles → no valid_out, active=0.
- Aligned lock: 4×8'hBC then 8'hA5, 8'h3C → active rises on last COM bit; valid_out pulses with out=A5, then out=3C exactly 8 cycles later.
- Bit offset: 3 garbage bits, then 4×BC, then 8'h5A → lock acquired; out=5A on its 8th bit edge.
- Broken sequence: 3×BC, 8'h55, then 4×BC, 8'h11 → return to SEARCH after 55, no pulse for 55; relock; out=11.
- Idle and reset while locked: after lock send BC, 8'h77, then reset mid-word → no pulse for BC; out=77 pulse; reset clears out/active asynchronously; the next 4 COMs are required before any pulse.
- LOCK_LOSS_EN: after lock send 16 non-COM words 8'h01..8'h10 → 16 pulses, active falls on the 16th word edge. Without the macro, active stays 1.

Source files
------------

// File: rtl/serial_to_parallel_rx_if.sv
// rtl/serial_to_parallel_rx_if.sv - serial lane in / deserialized word out bundle
// Signals: in (serial bit, MSB first), out (last delivered word),
//          valid_out (one-cycle new-word pulse), active (receiver locked).
// Modports: master = lane driver / word consumer, slave = receiver.
interface serial_to_parallel_rx_if #(
    parameter int DATA_SIZE = 8
);
    logic                 in;
    logic [DATA_SIZE-1:0] out;
    logic                 valid_out;
    logic                 active;

    modport master (
        output in,
        input  out,
        input  valid_out,
        input  active
    );

    modport slave (
        input  in,
        output out,
        output valid_out,
        output active
    );
endinterface

// File: rtl/serial_to_parallel_rx.sv
// rtl/serial_to_parallel_rx.sv - serial lane deserializer with COM-character alignment and lock
// Ports: clk (one serial bit per rising edge), reset (async, active-high),
//        lane (serial_to_parallel_rx_if.slave: in, out, valid_out, active).
// Optional macro LOCK_LOSS_EN: drop lock after LOSS_BYTES consecutive non-COM words.
module serial_to_parallel_rx #(
    parameter int                   DATA_SIZE  = 8,
    parameter logic [DATA_SIZE-1:0] COM_CHAR   = DATA_SIZE'(8'hBC),
    parameter int                   LOCK_COUNT = 4,
    parameter int                   LOSS_BYTES = 16
) (
    input logic                   clk,
    input logic                   reset,
    serial_to_parallel_rx_if.slave lane
);
    localparam int BW = $clog2(DATA_SIZE);
    localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_SIZE - 1);
    localparam logic [3:0]    LOCK_TARGET = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t               state_q, state_d;
    // Only the newest DATA_SIZE-1 bits need storing; the incoming bit completes the window.
    logic [DATA_SIZE-2:0] sr_q, sr_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]           com_cnt_q, com_cnt_d;
    logic [DATA_SIZE-1:0] out_q, out_d;
    logic                 valid_q, valid_d;
    logic                 active_q, active_d;

    logic [DATA_SIZE-1:0] window;
    logic                 is_com;
    logic                 boundary;
    logic [3:0]           com_inc;
    logic [BW-1:0]        bit_next;

    // Every decision uses the word that includes the bit sampled on this edge.
    assign window   = {sr_q, lane.in};
    assign is_com   = (window == COM_CHAR);
    assign boundary = (bit_cnt_q == LAST_BIT);
    assign com_inc  = com_cnt_q + 4'd1;
    assign bit_next = boundary ? '0 : bit_cnt_q + 1'b1;

`ifdef LOCK_LOSS_EN
    localparam int LW = $clog2(LOSS_BYTES + 1);
    localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_BYTES - 1);
    logic [LW-1:0] loss_cnt_q, loss_cnt_d;
`else
    logic [31:0] unused_loss_bytes;
    assign unused_loss_bytes = LOSS_BYTES;
`endif

    always_comb begin
        state_d   = state_q;
        sr_d      = window[DATA_SIZE-2:0];
        bit_cnt_d = bit_cnt_q;
        com_cnt_d = com_cnt_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        active_d  = active_q;
`ifdef LOCK_LOSS_EN
        loss_cnt_d = loss_cnt_q;
`endif
        case (state_q)
            SEARCH: begin
                // Hunt on every bit position; the detected COM defines the word phase.
                if (is_com) begin
                    bit_cnt_d = '0;
                    com_cnt_d = 4'd1;
                    if (LOCK_COUNT == 1) begin
                        state_d  = LOCKED;
                        active_d = 1'b1;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                bit_cnt_d = bit_next;
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_d = com_inc;
                        if (com_inc == LOCK_TARGET) begin
                            state_d  = LOCKED;
                            active_d = 1'b1;
                        end
                    end else begin
                        com_cnt_d = '0;
                        state_d   = SEARCH;
                    end
                end
            end
            LOCKED: begin
                bit_cnt_d = bit_next;
                if (boundary) begin
                    if (!is_com) begin
                        out_d   = window;
                        valid_d = 1'b1;
`ifdef LOCK_LOSS_EN
                        // The word that exhausts the budget is still delivered.
                        if (loss_cnt_q == LOSS_LAST) begin
                            loss_cnt_d = '0;
                            state_d    = SEARCH;
                            active_d   = 1'b0;
                            com_cnt_d  = '0;
                        end else begin
                            loss_cnt_d = loss_cnt_q + 1'b1;
                        end
`endif
                    end else begin
`ifdef LOCK_LOSS_EN
                        loss_cnt_d = '0;
`endif
                    end
                end
            end
            default: begin
                state_d  = SEARCH;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SEARCH;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            com_cnt_q <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
`ifdef LOCK_LOSS_EN
            loss_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
`ifdef LOCK_LOSS_EN
            loss_cnt_q <= loss_cnt_d;
`endif
        end
    end

    assign lane.out       = out_q;
    assign lane.valid_out = valid_q;
    assign lane.active    = active_q;
endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// tb/tb_serial_to_parallel_rx.sv - directed self-checking bench for serial_to_parallel_rx
module tb_serial_to_parallel_rx;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_to_parallel_rx_if #(.DATA_SIZE(8)) lane_if ();

    serial_to_parallel_rx #(
        .DATA_SIZE (8),
        .COM_CHAR  (8'hBC),
        .LOCK_COUNT(4),
        .LOSS_BYTES(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .lane (lane_if)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pulse_cyc = -1;

    // Drive on the falling edge, observe 1 ns after the rising edge.
    task automatic send_bit(input logic b);
        @(negedge clk);
        lane_if.in = b;
        @(posedge clk);
        #1;
        cyc++;
        if (lane_if.valid_out) pulse_cyc = cyc;
    endtask

    task automatic send_byte(input logic [7:0] v, output int np, output int pbit,
                             output logic [7:0] out_end, output logic act_pre, output logic act_end);
        np = 0; pbit = -1; act_pre = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i]);
            if (lane_if.valid_out) begin np++; pbit = 7 - i; end
            if (i == 1) act_pre = lane_if.active;
        end
        out_end = lane_if.out;
        act_end = lane_if.active;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        lane_if.in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic lock_up();
        int np, pb; logic [7:0] o; logic ap, ae;
        for (int k = 0; k < 4; k++) send_byte(8'hBC, np, pb, o, ap, ae);
    endtask

    task automatic test_reset();
        int np_total; logic act_seen;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (lane_if.out !== 8'h00) begin failures++; $display("FAIL reset_out got=%0h exp=0", lane_if.out); end
        checks++; if (lane_if.valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", lane_if.valid_out); end
        checks++; if (lane_if.active !== 1'b0) begin failures++; $display("FAIL reset_active got=%0b exp=0", lane_if.active); end
        @(negedge clk);
        reset = 1'b0;
        np_total = 0; act_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            send_bit(1'b0);
            if (lane_if.valid_out) np_total++;
            if (lane_if.active) act_seen = 1'b1;
        end
        checks++; if (np_total !== 0) begin failures++; $display("FAIL zeros_pulses got=%0d exp=0", np_total); end
        checks++; if (act_seen !== 1'b0) begin failures++; $display("FAIL zeros_active got=%0b exp=0", act_seen); end
    endtask

    task automatic test_aligned_lock();
        int np, pb, c1; logic [7:0] o; logic ap, ae;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            send_byte(8'hBC, np, pb, o, ap, ae);
            checks++; if (np !== 0 || ae !== 1'b0) begin failures++; $display("FAIL align_com%0d got=np%0d/act%0b exp=np0/act0", k, np, ae); end
        end
        send_byte(8'hBC, np, pb, o, ap, ae);
        checks++; if (ap !== 1'b0 || ae !== 1'b1) begin failures++; $display("FAIL lock_edge got=pre%0b/end%0b exp=pre0/end1", ap, ae); end
        send_byte(8'hA5, np, pb, o, ap, ae);
        c1 = pulse_cyc;
        checks++; if (np !== 1 || pb !== 7 || o !== 8'hA5) begin failures++; $display("FAIL word_a5 got=np%0d/bit%0d/%0h exp=np1/bit7/a5", np, pb, o); end
        send_byte(8'h3C, np, pb, o, ap, ae);
        checks++; if (np !== 1 || o !== 8'h3C) begin failures++; $display("FAIL word_3c got=np%0d/%0h exp=np1/3c", np, o); end
        checks++; if (pulse_cyc - c1 !== 8) begin failures++; $display("FAIL pulse_spacing got=%0d exp=8", pulse_cyc - c1); end
    endtask

    task automatic test_bit_offset();
        int np, pb; logic [7:0] o; logic ap, ae;
        apply_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        lock_up();
        checks++; if (lane_if.active !== 1'b1) begin failures++; $display("FAIL offset_lock got=%0b exp=1", lane_if.active); end
        send_byte(8'h5A, np, pb, o, ap, ae);
        checks++; if (np !== 1 || pb !== 7 || o !== 8'h5A) begin failures++; $display("FAIL offset_word got=np%0d/bit%0d/%0h exp=np1/bit7/5a", np, pb, o); end
    endtask

    task automatic test_broken_sequence();
        int np, pb; logic [7:0] o; logic ap, ae;
        apply_reset();
        for (int k = 0; k < 3; k++) send_byte(8'hBC, np, pb, o, ap, ae);
        send_byte(8'h55, np, pb, o, ap, ae);
        checks++; if (np !== 0 || ae !== 1'b0 || o !== 8'h00) begin failures++; $display("FAIL broken_55 got=np%0d/act%0b/%0h exp=np0/act0/0", np, ae, o); end
        lock_up();
        checks++; if (lane_if.active !== 1'b1) begin failures++; $display("FAIL relock got=%0b exp=1", lane_if.active); end
        send_byte(8'h11, np, pb, o, ap, ae);
        checks++; if (np !== 1 || o !== 8'h11) begin failures++; $display("FAIL relock_word got=np%0d/%0h exp=np1/11", np, o); end
    endtask

    task automatic test_idle_and_reset();
        int np, pb; logic [7:0] o; logic ap, ae;
        apply_reset();
        lock_up();
        send_byte(8'hBC, np, pb, o, ap, ae);
        checks++; if (np !== 0 || ae !== 1'b1) begin failures++; $display("FAIL idle_com got=np%0d/act%0b exp=np0/act1", np, ae); end
        send_byte(8'h77, np, pb, o, ap, ae);
        checks++; if (np !== 1 || o !== 8'h77) begin failures++; $display("FAIL idle_word got=np%0d/%0h exp=np1/77", np, o); end
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        checks++; if (lane_if.out !== 8'h77 || lane_if.valid_out !== 1'b0) begin failures++; $display("FAIL hold_out got=%0h/v%0b exp=77/v0", lane_if.out, lane_if.valid_out); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (lane_if.out !== 8'h00 || lane_if.valid_out !== 1'b0 || lane_if.active !== 1'b0) begin
            failures++; $display("FAIL async_reset got=%0h/v%0b/a%0b exp=0/v0/a0", lane_if.out, lane_if.valid_out, lane_if.active);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send_byte(8'hBC, np, pb, o, ap, ae);
            checks++; if (np !== 0 || ae !== 1'b0) begin failures++; $display("FAIL relock_com%0d got=np%0d/act%0b exp=np0/act0", k, np, ae); end
        end
        send_byte(8'hBC, np, pb, o, ap, ae);
        checks++; if (ae !== 1'b1) begin failures++; $display("FAIL relock_4th got=%0b exp=1", ae); end
        send_byte(8'h99, np, pb, o, ap, ae);
        checks++; if (np !== 1 || o !== 8'h99) begin failures++; $display("FAIL after_reset_word got=np%0d/%0h exp=np1/99", np, o); end
    endtask

    task automatic test_lock_loss();
        int np, pb; logic [7:0] o; logic ap, ae;
        logic exp_act_end; int exp_np_after;
`ifdef LOCK_LOSS_EN
        exp_act_end = 1'b0; exp_np_after = 0;
`else
        exp_act_end = 1'b1; exp_np_after = 1;
`endif
        apply_reset();
        lock_up();
        for (int w = 1; w <= 16; w++) begin
            send_byte(8'(w), np, pb, o, ap, ae);
            checks++; if (np !== 1 || o !== 8'(w)) begin failures++; $display("FAIL loss_word%0d got=np%0d/%0h exp=np1/%0h", w, np, o, w); end
            if (w == 16) begin
                checks++; if (ap !== 1'b1 || ae !== exp_act_end) begin failures++; $display("FAIL loss_active got=pre%0b/end%0b exp=pre1/end%0b", ap, ae, exp_act_end); end
            end
        end
        send_byte(8'h11, np, pb, o, ap, ae);
        checks++; if (np !== exp_np_after) begin failures++; $display("FAIL loss_after got=np%0d exp=np%0d", np, exp_np_after); end
    endtask

    initial begin
        reset = 1'b1;
        lane_if.in = 1'b0;
        #12;
        reset = 1'b0;
        test_reset();
        test_aligned_lock();
        test_bit_offset();
        test_broken_sequence();
        test_idle_and_reset();
        test_lock_loss();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
